// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Decodes register read/write command frames popped from the RX FIFO of the
//   buffered UART. Drives an 8-bit register bus and pushes exactly one response
//   byte per frame into the TX FIFO.
//     'W'(0x57) addr data -> register write, respond 'K'(0x4B)
//     'R'(0x52) addr      -> register read, respond with the read byte
//     other first byte    -> respond 'E'(0x45), bump the error counter
//   Optional feature macro: UART_BRIDGE_TIMEOUT_EN
//     When it is defined, a frame that stalls for pTimeoutCycles clocks waiting
//     for its address or data byte is dropped. The bridge then answers 'E' and
//     bumps the error counter. When it is undefined, partial frames wait forever.
// Ports
//   iClk, iRst                     clock, asynchronous active-high reset
//   oRxRdEn, iRxEmpty, iRxData     RX FIFO read port (data valid the cycle after pop)
//   oTxWrEn, iTxFull, oTxData      TX FIFO write port
//   oRegAddr, oRegWrEn, oRegWrData register write strobe + address/data
//   oRegRdEn, iRegRdData           register read strobe (data valid the next cycle)
//   oBusy                          high while a frame is in progress
//   oErrCnt                        saturating count of bad opcodes and timeouts
module uart_reg_bridge #(
    parameter int pTimeoutCycles = 1_200_000,
    parameter int pErrCntWidth   = 8
) (
    input  logic                    iClk,
    input  logic                    iRst,
    output logic                    oRxRdEn,
    input  logic                    iRxEmpty,
    input  logic [7:0]              iRxData,
    output logic                    oTxWrEn,
    input  logic                    iTxFull,
    output logic [7:0]              oTxData,
    output logic [7:0]              oRegAddr,
    output logic                    oRegWrEn,
    output logic [7:0]              oRegWrData,
    output logic                    oRegRdEn,
    input  logic [7:0]              iRegRdData,
    output logic                    oBusy,
    output logic [pErrCntWidth-1:0] oErrCnt
);

    typedef enum logic [3:0] {
        S_OP_POP,
        S_OP_CAP,
        S_ADDR_POP,
        S_ADDR_CAP,
        S_DATA_POP,
        S_DATA_CAP,
        S_REG_WR,
        S_REG_RD,
        S_REG_CAP,
        S_RESP
    } state_t;

    localparam logic [7:0] OP_WR  = 8'h57;
    localparam logic [7:0] OP_RD  = 8'h52;
    localparam logic [7:0] RSP_OK = 8'h4B;
    localparam logic [7:0] RSP_ER = 8'h45;

    state_t                  r_state;
    logic                    r_is_wr;
    logic [7:0]              r_addr;
    logic [7:0]              r_wr_data;
    logic [7:0]              r_tx_data;
    logic [pErrCntWidth-1:0] r_err_cnt;

    logic w_pop_state;
    logic w_pop;
    logic w_push;
    logic w_bad_op;
    logic w_err_inc;
    logic w_timeout;

    // The pop strobe is decoded from state and iRxEmpty rather than registered.
    // This keeps the FIFO from ever being popped while empty. It is also forced
    // low while reset is held.
    assign w_pop_state = (r_state == S_OP_POP) || (r_state == S_ADDR_POP) ||
                         (r_state == S_DATA_POP);
    assign w_pop       = w_pop_state && !iRxEmpty && !iRst;
    assign w_push      = (r_state == S_RESP) && !iTxFull;
    assign w_bad_op    = (r_state == S_OP_CAP) && (iRxData != OP_WR) && (iRxData != OP_RD);
    assign w_err_inc   = w_bad_op || w_timeout;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(pTimeoutCycles + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_wait;

    // Down-counter reloaded on every pop. It runs only while a frame is
    // stalled mid-way, so the idle opcode wait can never time out.
    assign w_to_wait = ((r_state == S_ADDR_POP) || (r_state == S_DATA_POP)) && iRxEmpty;
    assign w_timeout = w_to_wait && (r_to_cnt == '0);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_to_cnt <= TO_W'(pTimeoutCycles - 1);
        end else if (w_pop) begin
            r_to_cnt <= TO_W'(pTimeoutCycles - 1);
        end else if (w_to_wait && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state   <= S_OP_POP;
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                S_OP_POP: begin
                    if (w_pop) r_state <= S_OP_CAP;
                end
                S_OP_CAP: begin
                    r_is_wr <= (iRxData == OP_WR);
                    if ((iRxData == OP_WR) || (iRxData == OP_RD)) begin
                        r_state <= S_ADDR_POP;
                    end else begin
                        r_tx_data <= RSP_ER;
                        r_state   <= S_RESP;
                    end
                end
                S_ADDR_POP: begin
                    if (w_pop) begin
                        r_state <= S_ADDR_CAP;
                    end else if (w_timeout) begin
                        r_tx_data <= RSP_ER;
                        r_state   <= S_RESP;
                    end
                end
                S_ADDR_CAP: begin
                    r_addr  <= iRxData;
                    r_state <= r_is_wr ? S_DATA_POP : S_REG_RD;
                end
                S_DATA_POP: begin
                    if (w_pop) begin
                        r_state <= S_DATA_CAP;
                    end else if (w_timeout) begin
                        r_tx_data <= RSP_ER;
                        r_state   <= S_RESP;
                    end
                end
                S_DATA_CAP: begin
                    r_wr_data <= iRxData;
                    r_state   <= S_REG_WR;
                end
                S_REG_WR: begin
                    r_tx_data <= RSP_OK;
                    r_state   <= S_RESP;
                end
                S_REG_RD: begin
                    r_state <= S_REG_CAP;
                end
                S_REG_CAP: begin
                    r_tx_data <= iRegRdData;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (!iTxFull) r_state <= S_OP_POP;
                end
                default: begin
                    r_state <= S_OP_POP;
                end
            endcase
        end
    end

    // Saturates at all-ones instead of wrapping.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign oRxRdEn    = w_pop;
    assign oTxWrEn    = w_push;
    assign oTxData    = r_tx_data;
    assign oRegAddr   = r_addr;
    assign oRegWrEn   = (r_state == S_REG_WR);
    assign oRegWrData = r_wr_data;
    assign oRegRdEn   = (r_state == S_REG_RD);
    assign oBusy      = (r_state != S_OP_POP);
    assign oErrCnt    = r_err_cnt;

endmodule
